// File: rtl/pc_sequencer.sv
// Fetch-stage PC controller.
// Owns the F-stage PC and picks its next value each cycle. Candidate sources
// are sequential fetch, a D-stage redirect, exception entry and ERET return.
// A redirect that arrives while fetch is stalled is parked in a pending
// register and applied on the first unstalled edge.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
    parameter logic [31:0] PC_LO     = 32'h0000_3000,
    parameter logic [31:0] PC_HI     = 32'h0000_6ffc
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        d_valid,
    input  logic [2:0]  npc_op,
    input  logic        d_jump,
    input  logic [31:0] d_pc,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] d_rs,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] F_pc,
    output logic        F_valid,
    output logic        F_adel,
    output logic        pend
);

    // Sequencer states: BOOT lasts exactly one edge after reset release,
    // HOLD means a redirect target is parked waiting for the stall to clear.
    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [2:0] OP_BR  = 3'd1;
    localparam logic [2:0] OP_JAL = 3'd2;
    localparam logic [2:0] OP_JR  = 3'd3;

    // Fetch-address error: misaligned or outside the legal fetch window.
    function automatic logic fetch_addr_err(input logic [31:0] addr);
        fetch_addr_err = (addr[1:0] != 2'b00) || (addr < PC_LO) || (addr > PC_HI);
    endfunction

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic        pend_q, pend_d;
    logic [31:0] tgt_q, tgt_d;

    logic        redirect_s;
    logic [31:0] target_s;
    logic [31:0] br_target_s;

    assign br_target_s = d_pc + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};

    // Decode whether D stage requests a redirect this cycle, and where to.
    always_comb begin
        redirect_s = 1'b0;
        target_s   = 32'h0000_0000;
        if (d_valid) begin
            case (npc_op)
                OP_BR: begin
                    redirect_s = d_jump;
                    target_s   = br_target_s;
                end
                OP_JAL: begin
                    redirect_s = 1'b1;
                    target_s   = {d_pc[31:28], imm26, 2'b00};
                end
                OP_JR: begin
                    redirect_s = 1'b1;
                    target_s   = d_rs;
                end
                default: begin
                    redirect_s = 1'b0;
                    target_s   = 32'h0000_0000;
                end
            endcase
        end else begin
            redirect_s = 1'b0;
            target_s   = 32'h0000_0000;
        end
    end

    // Next-PC selection: exception > ERET > stall > pending > redirect > +4.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        pend_d  = pend_q;
        tgt_d   = tgt_q;
        case (state_q)
            ST_BOOT: begin
                // First fetch of RESET_PC becomes valid; stall is ignored here.
                valid_d = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN, ST_HOLD: begin
                if (exc_req) begin
                    pc_d    = EXC_ENTRY;
                    valid_d = 1'b1;
                    pend_d  = 1'b0;
                    tgt_d   = 32'h0000_0000;
                    state_d = ST_RUN;
                end else if (eret_req) begin
                    pc_d    = epc;
                    valid_d = 1'b1;
                    pend_d  = 1'b0;
                    tgt_d   = 32'h0000_0000;
                    state_d = ST_RUN;
                end else if (stall) begin
                    // Only the first redirect seen during a stall is kept.
                    if ((state_q == ST_RUN) && redirect_s) begin
                        tgt_d   = target_s;
                        pend_d  = 1'b1;
                        state_d = ST_HOLD;
                    end else begin
                        tgt_d = tgt_q;
                    end
                end else if (state_q == ST_HOLD) begin
                    pc_d    = tgt_q;
                    pend_d  = 1'b0;
                    tgt_d   = 32'h0000_0000;
                    state_d = ST_RUN;
                end else if (redirect_s) begin
                    pc_d = target_s;
                end else begin
                    pc_d = pc_q + 32'd4;
                end
            end
            default: begin
                // Illegal encoding: restart cleanly from boot.
                state_d = ST_BOOT;
                pc_d    = RESET_PC;
                valid_d = 1'b0;
                pend_d  = 1'b0;
                tgt_d   = 32'h0000_0000;
            end
        endcase
    end

    // Sequencer state registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            pend_q  <= 1'b0;
            tgt_q   <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
            tgt_q   <= tgt_d;
        end
    end

    assign F_pc    = pc_q;
    assign F_valid = valid_q;
    assign pend    = pend_q;
    assign F_adel  = fetch_addr_err(pc_q);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a behavioural reference model is
// compared against the DUT every falling edge, and directed steps carry
// hand-computed literal expectations.
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_PC = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        stall = 1'b0;
    logic        d_valid = 1'b0;
    logic [2:0]  npc_op = 3'd0;
    logic        d_jump = 1'b0;
    logic [31:0] d_pc = 32'h0;
    logic [15:0] imm16 = 16'h0;
    logic [25:0] imm26 = 26'h0;
    logic [31:0] d_rs = 32'h0;
    logic        exc_req = 1'b0;
    logic        eret_req = 1'b0;
    logic [31:0] epc = 32'h0;
    logic [31:0] F_pc;
    logic        F_valid;
    logic        F_adel;
    logic        pend;

    int total = 0;
    int bad = 0;
    logic chk_en = 1'b0;

    pc_sequencer dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .d_valid(d_valid),
        .npc_op(npc_op), .d_jump(d_jump), .d_pc(d_pc), .imm16(imm16),
        .imm26(imm26), .d_rs(d_rs), .exc_req(exc_req), .eret_req(eret_req),
        .epc(epc), .F_pc(F_pc), .F_valid(F_valid), .F_adel(F_adel), .pend(pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic        m_boot, m_valid, m_pend;
    logic [31:0] m_pc, m_tgt;

    function automatic logic mdl_redirect();
        if (!d_valid) return 1'b0;
        if (npc_op == 3'd1) return d_jump;
        return (npc_op == 3'd2) || (npc_op == 3'd3);
    endfunction

    function automatic logic [31:0] mdl_target();
        logic [31:0] off;
        off = {{16{imm16[15]}}, imm16};
        if (npc_op == 3'd1) return d_pc + 32'd4 + off * 32'd4;
        if (npc_op == 3'd2) return (d_pc & 32'hF000_0000) | ({6'd0, imm26} * 32'd4);
        return d_rs;
    endfunction

    // Model update on each edge, following the next-PC priority rules.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_boot <= 1'b1; m_valid <= 1'b0; m_pend <= 1'b0;
            m_pc <= RST_PC; m_tgt <= 32'h0;
        end else if (m_boot) begin
            m_boot <= 1'b0; m_valid <= 1'b1;
        end else if (exc_req) begin
            m_pc <= EXC_PC; m_pend <= 1'b0;
        end else if (eret_req) begin
            m_pc <= epc; m_pend <= 1'b0;
        end else if (stall) begin
            if (!m_pend && mdl_redirect()) begin
                m_pend <= 1'b1; m_tgt <= mdl_target();
            end
        end else if (m_pend) begin
            m_pc <= m_tgt; m_pend <= 1'b0;
        end else if (mdl_redirect()) begin
            m_pc <= mdl_target();
        end else begin
            m_pc <= m_pc + 32'd4;
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_pc", F_pc, m_pc);
            check("model_valid", {31'd0, F_valid}, {31'd0, m_valid});
            check("model_pend", {31'd0, pend}, {31'd0, m_pend});
            check("model_adel", {31'd0, F_adel},
                  {31'd0, (m_pc[1:0] != 2'b00) || (m_pc < 32'h3000) || (m_pc > 32'h6ffc)});
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_d(input logic v, input logic [2:0] op, input logic j,
                         input logic [31:0] pc, input logic [15:0] i16,
                         input logic [25:0] i26, input logic [31:0] rs);
        d_valid = v; npc_op = op; d_jump = j; d_pc = pc;
        imm16 = i16; imm26 = i26; d_rs = rs;
    endtask

    initial begin
        #1 reset_n = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_pc", F_pc, 32'h3000);
        check("rst_valid", {31'd0, F_valid}, 32'd0);
        reset_n = 1'b1;

        // 1: boot then sequential fetch
        step();
        check("boot_pc", F_pc, 32'h3000);
        check("boot_valid", {31'd0, F_valid}, 32'd1);
        step();
        check("seq1", F_pc, 32'h3004);
        step();
        check("seq2", F_pc, 32'h3008);

        // 2: taken and not-taken branch
        set_d(1'b1, 3'd1, 1'b1, 32'h3010, 16'hFFFC, 26'h0, 32'h0);
        step();
        check("br_taken", F_pc, 32'h3004);
        d_jump = 1'b0;
        step();
        check("br_not_taken", F_pc, 32'h3008);
        set_d(1'b1, 3'd5, 1'b1, 32'h3010, 16'h0040, 26'h0, 32'h0);
        step();
        check("op5_is_com", F_pc, 32'h300c);

        // 3: JAL during a 3-cycle stall, later JR ignored
        stall = 1'b1;
        set_d(1'b1, 3'd2, 1'b0, 32'h3004, 16'h0, 26'h0000C40, 32'h0);
        step();
        check("hold_pc", F_pc, 32'h300c);
        check("hold_pend", {31'd0, pend}, 32'd1);
        set_d(1'b1, 3'd3, 1'b0, 32'h3004, 16'h0, 26'h0, 32'h5000);
        step();
        set_d(1'b0, 3'd0, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0);
        step();
        check("hold_pc3", F_pc, 32'h300c);
        stall = 1'b0;
        step();
        check("jal_applied", F_pc, 32'h3100);
        check("jal_pend", {31'd0, pend}, 32'd0);
        step();
        check("after_jal", F_pc, 32'h3104);

        // 4: exception while holding a pending redirect
        stall = 1'b1;
        set_d(1'b1, 3'd2, 1'b0, 32'h3104, 16'h0, 26'h0000C40, 32'h0);
        step();
        check("hold2_pend", {31'd0, pend}, 32'd1);
        set_d(1'b0, 3'd0, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0);
        exc_req = 1'b1;
        step();
        exc_req = 1'b0;
        check("exc_pc", F_pc, 32'h4180);
        check("exc_pend", {31'd0, pend}, 32'd0);
        step();
        check("exc_stalled", F_pc, 32'h4180);
        stall = 1'b0;
        step();
        check("no_stale_tgt", F_pc, 32'h4184);

        // 5: exc beats eret, then eret alone
        exc_req = 1'b1; eret_req = 1'b1; epc = 32'h3020;
        step();
        check("exc_wins", F_pc, 32'h4180);
        exc_req = 1'b0;
        step();
        eret_req = 1'b0;
        check("eret_pc", F_pc, 32'h3020);

        // 6: fetch-address errors, then async reset mid-HOLD
        set_d(1'b1, 3'd3, 1'b0, 32'h3020, 16'h0, 26'h0, 32'h3002);
        step();
        check("adel_misalign", {31'd0, F_adel}, 32'd1);
        d_rs = 32'h7000;
        step();
        check("adel_high", {31'd0, F_adel}, 32'd1);
        d_rs = 32'h6ffc;
        step();
        check("adel_edge_ok", {31'd0, F_adel}, 32'd0);
        set_d(1'b1, 3'd1, 1'b1, 32'hFFFF_FFF8, 16'h0001, 26'h0, 32'h0);
        step();
        check("br_wrap", F_pc, 32'h0000_0000);
        stall = 1'b1;
        set_d(1'b1, 3'd2, 1'b0, 32'h3000, 16'h0, 26'h0000C40, 32'h0);
        step();
        check("hold3_pend", {31'd0, pend}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_pc", F_pc, 32'h3000);
        check("async_pend", {31'd0, pend}, 32'd0);
        check("async_valid", {31'd0, F_valid}, 32'd0);
        stall = 1'b0;
        set_d(1'b0, 3'd0, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check("reboot_pc", F_pc, 32'h3000);
        step();
        check("reboot_seq", F_pc, 32'h3004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch-stage PC controller: owns the F-stage PC register and chooses its next value every cycle.
- Sources: sequential (PC+4), branch/J/JAL/JR redirect from D stage, exception entry, and ERET return.
- Handles hazard-unit stalls. A D-stage redirect that arrives while fetch is stalled is latched and applied once the stall releases.
- Flags fetch-address errors for the exception unit.

Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset.
- EXC_ENTRY, 32'h0000_4180, exception handler entry.
- PC_LO, 32'h0000_3000, lowest legal fetch address.
- PC_HI, 32'h0000_6ffc, highest legal fetch address.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- stall  input  1  hazard unit holds F (and D).
- d_valid  input  1  D-stage control-flow info below is meaningful this cycle.
- npc_op  input  3  0=COM, 1=BR, 2=JAL (J/JAL), 3=JR; 4-7 treated as COM.
- d_jump  input  1  branch condition resolved in D.
- d_pc  input  32  PC of the D-stage instruction.
- imm16  input  16  branch offset.
- imm26  input  26  jump index.
- d_rs  input  32  forwarded rs value for JR.
- exc_req  input  1  take exception (one-cycle pulse).
- eret_req  input  1  return from exception (one-cycle pulse).
- epc  input  32  return address for ERET.
- F_pc  output  32  current fetch PC.
- F_valid  output  1  F_pc is a real fetch (0 = bubble).
- F_adel  output  1  F_pc misaligned or outside [PC_LO, PC_HI].
- pend  output  1  a redirect is latched and waiting.

Behaviour:
- Reset (reset_n=0, any time, including mid-redirect):
  - F_pc=RESET_PC, F_valid=0, pend=0, pending target cleared, state=BOOT.
- States:
  - BOOT: first edge after reset release: F_valid←1, F_pc unchanged (stays RESET_PC), go to RUN. stall is ignored in BOOT.
  - RUN: normal fetch.
  - HOLD: redirect latched during stall; pend=1.
- Redirect targets:
  - BR: d_pc + 4 + {{14{imm16[15]}}, imm16, 2'b00}, 32-bit wrap-around, no overflow detection.
  - JAL: {d_pc[31:28], imm26, 2'b00}.
  - JR: d_rs, unmodified.
- A redirect exists when d_valid=1 and either npc_op=BR with d_jump=1, or npc_op=JAL, or npc_op=JR.
- Next-PC priority each edge in RUN/HOLD:
  1. exc_req: F_pc←EXC_ENTRY, F_valid←1, pending cleared, state=RUN. Ignores stall.
  2. eret_req: F_pc←epc, F_valid←1, pending cleared, state=RUN. Ignores stall.
  3. stall=1:
     - F_pc holds.
     - If RUN and a redirect exists: latch its target, state=HOLD.
     - If already HOLD: keep the first latched target; later redirects are ignored.
  4. stall=0, state=HOLD: F_pc←latched target, state=RUN, pend=0.
  5. stall=0, RUN, redirect exists: F_pc←target.
  6. Otherwise: F_pc←F_pc+4, wrapping at 2^32.
- Latency:
  - Redirect to new F_pc: 1 cycle.
  - Pending redirect: applied on the first edge where stall=0.
  - Total latency: stalled cycles + 1.
- The delay-slot instruction is fetched normally; this block never squashes it.
- exc_req and eret_req asserted together: exc_req wins.
- F_adel is combinational from F_pc: F_pc[1:0]≠0, or F_pc<PC_LO, or F_pc>PC_HI.
- The block does not redirect on F_adel; the exception unit raises exc_req.
- F_valid is 0 only in BOOT. After that it stays 1 until the next reset.

Test Plan:
1. Reset release, no stall → F_pc 0x3000 for two cycles (BOOT), F_valid 0 then 1, then 0x3004, 0x3008.
2. d_valid=1, npc_op=BR, d_jump=1, d_pc=0x3010, imm16=0xFFFC → next F_pc=0x3004. Same with d_jump=0 → F_pc+4.
3. stall=1 for 3 cycles; JAL with imm26=0x0000C40 in the first stalled cycle → F_pc frozen, pend=1. When stall drops: F_pc=0x00003100, pend=0.
4. In HOLD with pending target 0x3100, exc_req pulse while stall=1 → F_pc=0x4180, pend=0. The pending target never appears on F_pc.
5. Same cycle: exc_req=1, eret_req=1, epc=0x3020 → F_pc=0x4180. Next cycle eret_req alone → F_pc=0x3020.
6. JR with d_rs=0x3002 → F_adel=1. JR with d_rs=0x7000 → F_adel=1. Assert reset_n=0 mid-HOLD → F_pc=0x3000, pend=0, F_valid=0 with no clock edge needed.
